// File: rtl/counter_pkg.sv
// counter_pkg: state encoding and default width shared by the up and down counters
package counter_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } cnt_state_t;
  localparam int CNT_WIDTH = 32;
endpackage

// File: rtl/down_counter_32bit.sv
// down_counter_32bit: loadable down counter/timer with one-shot or auto-reload underflow
//   clk, rst (async, active high)
//   enable      decrement qualifier, acts only in RUN
//   load        load strobe; captures load_value and auto_reload, enters RUN
//   load_value  start/reload value
//   auto_reload 1 = periodic, 0 = one-shot
//   stop        abort strobe, returns to IDLE
//   count       registered count value
//   underflow   one-cycle pulse when an enabled decrement hits zero
//   busy        state is RUN
//   done        state is DONE (one-shot expired)
module down_counter_32bit
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             underflow,
  output logic             busy,
  output logic             done
);
  cnt_state_t       state, state_n;
  logic [WIDTH-1:0] reload_reg, count_n;
  logic             mode_reg, fire, hold;
  // fire: an enabled cycle at zero in RUN that no higher-priority strobe overrides
  always_comb begin
    fire    = state == RUN && enable && count == '0 && !load && !stop;
    hold    = stop || state != RUN || !enable;
    state_n = load ? RUN : stop ? IDLE : fire ? (mode_reg ? RUN : DONE) : state;
    count_n = load ? load_value : hold ? count :
              count == '0 ? (mode_reg ? reload_reg : '0) : count - 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      mode_reg   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      underflow <= fire;
      if (load) begin
        reload_reg <= load_value;
        mode_reg   <= auto_reload;
      end
    end
  end
  assign busy = state == RUN;
  assign done = state == DONE;
endmodule

// File: tb/tb_down_counter_32bit.sv
// tb_down_counter_32bit: directed and randomized checks against a behavioural model
module tb_down_counter_32bit;
  logic        clk = 1'b0;
  logic        rst, enable, load, auto_reload, stop;
  logic [31:0] load_value;
  logic [31:0] count;
  logic        underflow, busy, done;
  int          passed = 0, total = 0;
  int          m_st;
  logic [31:0] m_cnt, m_rel;
  bit          m_mode, m_uf;
  int          pulses;

  down_counter_32bit dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .load_value(load_value),
    .auto_reload(auto_reload), .stop(stop), .count(count), .underflow(underflow),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_rel = 0; m_mode = 0; m_uf = 0;
  endtask

  task automatic model_step();
    m_uf = 0;
    if (load) begin
      m_cnt = load_value; m_rel = load_value; m_mode = auto_reload; m_st = 1;
    end else if (stop) m_st = 0;
    else if (m_st == 1 && enable) begin
      if (m_cnt != 0) m_cnt = m_cnt - 1;
      else begin
        m_uf = 1;
        if (m_mode) m_cnt = m_rel;
        else m_st = 2;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".count"}, count, m_cnt);
    check({tag, ".underflow"}, underflow, m_uf);
    check({tag, ".busy"}, busy, m_st == 1);
    check({tag, ".done"}, done, m_st == 2);
  endtask

  task automatic cyc(input bit ld, input logic [31:0] lv, input bit ar, input bit sp,
                     input bit en, input string tag);
    load = ld; load_value = lv; auto_reload = ar; stop = sp; enable = en;
    @(posedge clk); #1;
    model_step();
    compare_all(tag);
  endtask

  initial begin
    rst = 1; enable = 0; load = 0; stop = 0; auto_reload = 0; load_value = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst = 0;
    // reset mid-count at 5
    cyc(1, 8, 0, 0, 0, "rst_load");
    repeat (3) cyc(0, 0, 0, 0, 1, "rst_run");
    check("rst_pre_count", count, 5);
    #2 rst = 1;
    #1;
    model_reset();
    check("rst_async_count", count, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_uf", underflow, 0);
    @(posedge clk); #1 rst = 0;
    repeat (3) cyc(0, 0, 0, 0, 1, "idle_en");
    check("idle_count", count, 0);
    // one-shot 3,2,1,0 then underflow + done
    cyc(1, 3, 0, 0, 1, "os_load");
    check("os_c3", count, 3);
    cyc(0, 0, 0, 0, 1, "os"); check("os_c2", count, 2);
    cyc(0, 0, 0, 0, 1, "os"); check("os_c1", count, 1);
    cyc(0, 0, 0, 0, 1, "os"); check("os_c0", count, 0);
    cyc(0, 0, 0, 0, 1, "os");
    check("os_uf", underflow, 1);
    check("os_done", done, 1);
    cyc(0, 0, 0, 0, 1, "os");
    check("os_uf_once", underflow, 0);
    check("os_hold", {done, count}, {1'b1, 32'd0});
    // auto-reload period 3
    cyc(1, 2, 1, 0, 1, "ar_load");
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 0, 0, 1, "ar");
      pulses += underflow;
    end
    check("ar_pulses", pulses, 4);
    // enable gating
    cyc(1, 10, 0, 0, 0, "eg_load");
    cyc(0, 0, 0, 0, 1, "eg"); check("eg_9", count, 9);
    cyc(0, 0, 0, 0, 0, "eg");
    cyc(0, 0, 0, 0, 0, "eg"); check("eg_hold", count, 9);
    cyc(0, 0, 0, 0, 1, "eg"); check("eg_8", count, 8);
    // load beats underflow
    cyc(1, 0, 0, 0, 0, "col_load0");
    cyc(1, 32'h20, 0, 0, 1, "col_load");
    check("col_load_count", count, 32'h20);
    check("col_load_uf", underflow, 0);
    // stop beats underflow
    cyc(1, 0, 1, 0, 0, "col_stop0");
    cyc(0, 0, 0, 1, 1, "col_stop");
    check("col_stop_state", {busy, done, underflow}, 3'b000);
    // wide value
    cyc(1, 32'hFFFF_FFFF, 1, 0, 0, "wide_load");
    cyc(0, 0, 0, 0, 1, "wide");
    check("wide_dec", count, 32'hFFFF_FFFE);
    cyc(1, 0, 1, 0, 0, "zero_load");
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 1, "zero_ar");
      check("zero_ar_uf", underflow, 1);
    end
    // randomized
    for (int i = 0; i < 600; i++) begin
      logic [31:0] lv;
      lv = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 6);
      cyc($urandom_range(0, 11) == 0, lv, $urandom_range(0, 1), $urandom_range(0, 24) == 0,
          $urandom_range(0, 3) != 0, "rand");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
